data_cache_ctrl: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between the cpu data port and data_memory.
//  CPU side is the responder of the read/write/address/writedata/readdata/busywait protocol (same
//  as data_memory presents). Memory side is the initiator of that protocol towards data_memory.

---
 rtl/data_cache_ctrl_pkg.sv | 45 ++++
 rtl/data_cache_ctrl_if.sv | 30 +++
 rtl/data_cache_ctrl_line_store.sv | 54 +++++
 rtl/data_cache_ctrl.sv | 155 +++++++++++++++
 tb/tb_data_cache_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_cache_ctrl_pkg.sv
// Shared types, widths and address helpers for the direct-mapped data cache.
package data_cache_ctrl_pkg;

  localparam int unsigned AddrW      = 8;
  localparam int unsigned DataW      = 8;
  localparam int unsigned NumSets    = 8;
  localparam int unsigned BlockBytes = 4;

  localparam int unsigned IdxW = $clog2(NumSets);
  localparam int unsigned OffW = $clog2(BlockBytes);
  localparam int unsigned TagW = AddrW - IdxW - OffW;

  typedef logic [AddrW-1:0] addr_t;
  typedef logic [DataW-1:0] data_t;
  typedef logic [TagW-1:0]  tag_t;
  typedef logic [IdxW-1:0]  idx_t;
  typedef logic [OffW-1:0]  off_t;

  typedef enum logic [2:0] {
    StIdle,
    StWb,
    StWbGap,
    StFetch,
    StFeGap,
    StUpdate
  } cache_state_e;

  // Byte address layout is {tag, index, offset}.
  function automatic tag_t addr_tag(addr_t a);
    return a[AddrW-1 -: TagW];
  endfunction

  function automatic idx_t addr_idx(addr_t a);
    return a[OffW +: IdxW];
  endfunction

  function automatic off_t addr_off(addr_t a);
    return a[OffW-1:0];
  endfunction

  function automatic addr_t make_addr(tag_t t, idx_t i, off_t o);
    return {t, i, o};
  endfunction

endpackage

// File: rtl/data_cache_ctrl_if.sv
// Read/write/busywait byte bus; used for both the cpu port and the memory port.
interface data_cache_ctrl_if;
  import data_cache_ctrl_pkg::*;

  logic  read;
  logic  write;
  addr_t address;
  data_t writedata;
  data_t readdata;
  logic  busywait;

  modport master (
    output read,
    output write,
    output address,
    output writedata,
    input  readdata,
    input  busywait
  );

  modport slave (
    input  read,
    input  write,
    input  address,
    input  writedata,
    output readdata,
    output busywait
  );

endinterface

// File: rtl/data_cache_ctrl_line_store.sv
// Line storage: tag/valid/dirty/data arrays, one combinational read port and one byte write port.
module data_cache_ctrl_line_store
  import data_cache_ctrl_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  idx_t  idx_i,
  input  off_t  rd_off_i,
  output logic  valid_o,
  output logic  dirty_o,
  output tag_t  tag_o,
  output data_t rd_data_o,
  input  logic  wr_en_i,
  input  off_t  wr_off_i,
  input  data_t wr_data_i,
  input  logic  wr_dirty_i,
  input  logic  fill_en_i,
  input  tag_t  fill_tag_i
);

  logic [NumSets-1:0] valid_q;
  logic [NumSets-1:0] dirty_q;
  tag_t               tag_q  [NumSets];
  data_t              data_q [NumSets][BlockBytes];

  assign valid_o   = valid_q[idx_i];
  assign dirty_o   = dirty_q[idx_i];
  assign tag_o     = tag_q[idx_i];
  assign rd_data_o = data_q[idx_i][rd_off_i];

  // Line flags: sync clear; a fill commits a clean line, a cpu byte write marks it dirty.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (wr_en_i && wr_dirty_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tags and bytes carry no reset; the valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (fill_en_i) begin
      tag_q[idx_i] <= fill_tag_i;
    end
    if (wr_en_i) begin
      data_q[idx_i][wr_off_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache: zero-stall hits, miss handled by a
// write-back/refill FSM that moves one byte per memory beat with a gap cycle between beats.
module data_cache_ctrl
  import data_cache_ctrl_pkg::*;
(
  input logic               clk_i,
  input logic               rst_ni,
  data_cache_ctrl_if.slave  cpu_io,
  data_cache_ctrl_if.master mem_io
);

  cache_state_e state_q, state_d;
  off_t         cnt_q, cnt_d;

  tag_t  req_tag;
  idx_t  req_idx;
  off_t  req_off;
  logic  req;
  logic  idle;
  logic  hit;

  logic  line_valid;
  logic  line_dirty;
  tag_t  line_tag;
  data_t line_data;

  off_t  rd_off;
  logic  st_wr_en;
  off_t  st_wr_off;
  data_t st_wr_data;
  logic  st_wr_dirty;
  logic  st_fill;

  logic  mem_read;
  logic  mem_write;
  addr_t mem_addr;
  data_t mem_wdata;

  assign req_tag = addr_tag(cpu_io.address);
  assign req_idx = addr_idx(cpu_io.address);
  assign req_off = addr_off(cpu_io.address);
  assign req     = cpu_io.read | cpu_io.write;
  assign idle    = (state_q == StIdle);
  assign hit     = line_valid && (line_tag == req_tag);

  assign cpu_io.busywait = req && !(idle && hit);
  // Read data is driven only for a read-only request that hits while idle.
  assign cpu_io.readdata = (cpu_io.read && !cpu_io.write && idle && hit) ? line_data : '0;

  assign mem_io.read      = mem_read;
  assign mem_io.write     = mem_write;
  assign mem_io.address   = mem_addr;
  assign mem_io.writedata = mem_wdata;

  data_cache_ctrl_line_store u_line_store (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .idx_i      (req_idx),
    .rd_off_i   (rd_off),
    .valid_o    (line_valid),
    .dirty_o    (line_dirty),
    .tag_o      (line_tag),
    .rd_data_o  (line_data),
    .wr_en_i    (st_wr_en),
    .wr_off_i   (st_wr_off),
    .wr_data_i  (st_wr_data),
    .wr_dirty_i (st_wr_dirty),
    .fill_en_i  (st_fill),
    .fill_tag_i (req_tag)
  );

  // State and beat counter; sync reset abandons any transfer in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, memory strobes and line-store write controls.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    rd_off      = req_off;
    st_wr_en    = 1'b0;
    st_wr_off   = req_off;
    st_wr_data  = cpu_io.writedata;
    st_wr_dirty = 1'b0;
    st_fill     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req && !hit) begin
          state_d = (line_valid && line_dirty) ? StWb : StFetch;
          cnt_d   = '0;
        end else if (cpu_io.write && hit) begin
          st_wr_en    = 1'b1;
          st_wr_dirty = 1'b1;
        end
      end
      StWb: begin
        // Victim bytes are read through the shared port at the beat offset.
        rd_off    = cnt_q;
        mem_write = 1'b1;
        mem_addr  = make_addr(line_tag, req_idx, cnt_q);
        mem_wdata = line_data;
        if (!mem_io.busywait) begin
          state_d = StWbGap;
        end
      end
      StWbGap: begin
        if (cnt_q == off_t'(BlockBytes - 1)) begin
          cnt_d   = '0;
          state_d = StFetch;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = StWb;
        end
      end
      StFetch: begin
        mem_read = 1'b1;
        mem_addr = make_addr(req_tag, req_idx, cnt_q);
        if (!mem_io.busywait) begin
          st_wr_en   = 1'b1;
          st_wr_off  = cnt_q;
          st_wr_data = mem_io.readdata;
          state_d    = StFeGap;
        end
      end
      StFeGap: begin
        if (cnt_q == off_t'(BlockBytes - 1)) begin
          state_d = StUpdate;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = StFetch;
        end
      end
      StUpdate: begin
        st_fill = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Bench for data_cache_ctrl: behavioural byte memory with programmable latency, directed
// scenarios followed by random accesses checked against a transparent-cache reference.
module tb_data_cache_ctrl;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } beat_t;

  localparam int Bound = 400;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  always #4 clk = ~clk;

  data_cache_ctrl_if cpu_if ();
  data_cache_ctrl_if mem_if ();

  data_cache_ctrl u_dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .cpu_io (cpu_if),
    .mem_io (mem_if)
  );

  // Backing memory: beat completes on the first posedge with busywait low.
  logic [7:0] mem      [256];
  logic [7:0] init_img [256];
  logic       load_en   = 1'b1;
  int         mem_lat   = 2;
  int         wait_cnt  = 0;
  int         both_high = 0;
  beat_t      beat_q [$];
  beat_t      rec;
  logic       strobe;

  assign strobe          = mem_if.read | mem_if.write;
  assign mem_if.busywait = strobe && (wait_cnt < mem_lat);
  assign mem_if.readdata = mem[mem_if.address];

  always @(posedge clk) begin
    if (load_en) begin
      for (int j = 0; j < 256; j++) mem[j] <= init_img[j];
    end
    if (strobe && wait_cnt < mem_lat) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
      if (strobe) begin
        rec.wr   = mem_if.write;
        rec.addr = mem_if.address;
        rec.data = mem_if.write ? mem_if.writedata : mem_if.readdata;
        beat_q.push_back(rec);
        if (mem_if.write) mem[mem_if.address] <= mem_if.writedata;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_if.read === 1'b1 && mem_if.write === 1'b1) both_high <= both_high + 1;
  end

  // Reference: golden is what the cpu must observe, ref_mem what memory should hold.
  logic [7:0] golden  [256];
  logic [7:0] ref_mem [256];
  bit         m_valid [8];
  bit         m_dirty [8];
  logic [2:0] m_tag   [8];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
      m_tag[s]   = '0;
    end
    // Dirty lines are lost on reset.
    for (int j = 0; j < 256; j++) golden[j] = ref_mem[j];
  endtask

  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, input string nm);
    beat_t      exp_q [$];
    beat_t      eb;
    int         exp_stall;
    int         stall;
    int         base;
    logic [7:0] exp_rd;
    logic [7:0] got_rd;
    logic [2:0] t;
    logic [2:0] i;
    logic [7:0] ba;
    exp_stall = 0;
    t = a[7:5];
    i = a[4:2];
    if (rd || wr) begin
      if (!(m_valid[i] && m_tag[i] == t)) begin
        if (m_valid[i] && m_dirty[i]) begin
          for (int b = 0; b < 4; b++) begin
            ba = {m_tag[i], i, 2'(b)};
            eb.wr = 1'b1; eb.addr = ba; eb.data = golden[ba];
            exp_q.push_back(eb);
            ref_mem[ba] = golden[ba];
          end
          exp_stall = 8 * (mem_lat + 2) + 2;
        end else begin
          exp_stall = 4 * (mem_lat + 2) + 2;
        end
        for (int b = 0; b < 4; b++) begin
          ba = {t, i, 2'(b)};
          eb.wr = 1'b0; eb.addr = ba; eb.data = ref_mem[ba];
          exp_q.push_back(eb);
        end
        m_valid[i] = 1'b1;
        m_tag[i]   = t;
        m_dirty[i] = 1'b0;
      end
      if (wr) begin
        golden[a]  = wd;
        m_dirty[i] = 1'b1;
      end
    end
    exp_rd = golden[a];
    base   = beat_q.size();

    @(negedge clk);
    cpu_if.read      = rd;
    cpu_if.write     = wr;
    cpu_if.address   = a;
    cpu_if.writedata = wd;
    stall = 0;
    #1;
    while (cpu_if.busywait === 1'b1 && stall < Bound) begin
      @(negedge clk);
      #1;
      stall++;
    end
    got_rd = cpu_if.readdata;
    @(posedge clk);
    #1;
    cpu_if.read  = 1'b0;
    cpu_if.write = 1'b0;

    check({nm, "_stall"}, stall, exp_stall);
    check({nm, "_nbeats"}, beat_q.size() - base, exp_q.size());
    for (int j = 0; j < exp_q.size() && base + j < beat_q.size(); j++) begin
      check($sformatf("%s_beat%0d", nm, j), beat_q[base + j], exp_q[j]);
    end
    if (rd && !wr) check({nm, "_rdata"}, got_rd, exp_rd);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_ni       = 1'b0;
    cpu_if.read  = 1'b0;
    cpu_if.write = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
  endtask

  initial begin
    int cyc;
    int base;
    int op;
    logic [7:0] a;
    logic [7:0] wd;

    cpu_if.read      = 1'b0;
    cpu_if.write     = 1'b0;
    cpu_if.address   = '0;
    cpu_if.writedata = '0;
    for (int j = 0; j < 256; j++) begin
      init_img[j] = 8'($urandom);
      ref_mem[j]  = init_img[j];
    end

    // Reset held two cycles: idle outputs.
    repeat (2) @(negedge clk);
    load_en = 1'b0;
    check("rst_busywait", cpu_if.busywait, 1'b0);
    check("rst_mem_read", mem_if.read, 1'b0);
    check("rst_mem_write", mem_if.write, 1'b0);
    check("rst_mem_addr", mem_if.address, 8'h00);
    check("rst_mem_wdata", mem_if.writedata, 8'h00);
    check("rst_readdata", cpu_if.readdata, 8'h00);
    rst_ni = 1'b1;
    model_reset();

    // Cold read miss, then write hit and read-back, then conflicting dirty eviction.
    access(1'b1, 1'b0, 8'h05, 8'h00, "cold_rd05");
    access(1'b0, 1'b1, 8'h06, 8'hAB, "hit_wr06");
    access(1'b1, 1'b0, 8'h06, 8'h00, "hit_rd06");
    access(1'b1, 1'b0, 8'h26, 8'h00, "evict_rd26");
    @(negedge clk);
    check("mem06_after_wb", mem[8'h06], 8'hAB);

    // Reset during the second fetch beat.
    pulse_reset();
    mem_lat = 3;
    base    = beat_q.size();
    @(negedge clk);
    cpu_if.read    = 1'b1;
    cpu_if.address = 8'h24;
    cyc = 0;
    while (!(beat_q.size() == base + 1 && mem_if.read === 1'b1) && cyc < Bound) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_reach_beat2", beat_q.size() - base, 1);
    rst_ni      = 1'b0;
    cpu_if.read = 1'b0;
    @(negedge clk);
    check("midrst_mem_read", mem_if.read, 1'b0);
    check("midrst_mem_write", mem_if.write, 1'b0);
    check("midrst_busywait", cpu_if.busywait, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
    check("midrst_beats", beat_q.size() - base, 1);
    access(1'b1, 1'b0, 8'h24, 8'h00, "refetch_rd24");

    // Simultaneous read and write behaves as a write with allocation.
    mem_lat = 1;
    access(1'b1, 1'b1, 8'h09, 8'h3C, "rw_09");
    access(1'b1, 1'b0, 8'h09, 8'h00, "rd_09");

    // Random traffic over a few tags to force conflicts and write-backs.
    for (int n = 0; n < 100; n++) begin
      op      = $urandom_range(0, 3);
      a       = {3'($urandom_range(0, 3)), 5'($urandom)};
      wd      = 8'($urandom);
      mem_lat = $urandom_range(0, 3);
      access(op[0] == 1'b1 || op == 3, op[1] == 1'b1, a, wd, $sformatf("rnd%0d", n));
    end

    check("strobes_never_both", both_high, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
